// File: rtl/quad_enc_counter_if.sv
// Quadrature counter bus: raw encoder pair and controls in, position and status out.
// master drives the encoder/controls, slave is the counter.
interface quad_enc_counter_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       enc_inp;
  logic             en;
  logic             clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step_valid;
  logic             ovf;
  logic             unf;
  logic             err;

  modport master (
    output enc_inp, en, clr,
    input  count, dir, step_valid, ovf, unf, err
  );

  modport slave (
    input  enc_inp, en, clr,
    output count, dir, step_valid, ovf, unf, err
  );
endinterface

// File: rtl/quad_enc_counter.sv
// Quadrature encoder position counter: 2-flop sync, stability filter, Gray decode,
// wrap/saturate counter with one-cycle step/limit pulses. All state moves on falling Clkb.
module quad_enc_counter #(
  parameter int CNT_W      = 8,
  parameter int FILT_DEPTH = 2,
  parameter int WRAP       = 1,
  parameter int MODE       = 0
) (
  input  logic              Clkb,
  input  logic              RST,
  quad_enc_counter_if.slave bus
);
  localparam int FC_W = 4;

  logic [1:0]       s1, s2, cand, qf, qf_d;
  logic [FC_W-1:0]  filt_cnt, filt_nxt;
  logic             accept;
  logic             init_arm;
  logic [CNT_W-1:0] count_r;
  logic             dir_r, sv_r, ovf_r, unf_r, err_r;
  logic             chg, illegal, fwd, step, at_max, at_min;

  // A run of identical s2 samples that differ from qf is counted; the run restarts
  // whenever the candidate value changes.
  always_comb begin
    filt_nxt = FC_W'(1);
    if ((filt_cnt != '0) && (s2 == cand))
      filt_nxt = filt_cnt + FC_W'(1);
    accept = (s2 != qf) && (filt_nxt >= FC_W'(FILT_DEPTH));
  end

  // Forward Gray order is 00->01->11->10->00; that holds exactly when old B differs
  // from new A.
  always_comb begin
    chg     = (qf != qf_d);
    illegal = ((qf ^ qf_d) == 2'b11);
    fwd     = qf_d[1] ^ qf[0];
    if (MODE == 0)
      step = chg && !illegal;
    else
      step = ((qf_d == 2'b10) && (qf == 2'b00)) || ((qf_d == 2'b00) && (qf == 2'b10));
    at_max = (count_r == {CNT_W{1'b1}});
    at_min = (count_r == '0);
  end

  always_ff @(negedge Clkb or posedge RST) begin
    if (RST) begin
      s1       <= 2'b00;
      s2       <= 2'b00;
      cand     <= 2'b00;
      qf       <= 2'b00;
      qf_d     <= 2'b00;
      filt_cnt <= '0;
      init_arm <= 1'b1;
      count_r  <= '0;
      dir_r    <= 1'b0;
      sv_r     <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      s1   <= bus.enc_inp;
      s2   <= s1;
      qf_d <= qf;

      if (s2 == qf) begin
        filt_cnt <= '0;
      end else if (accept) begin
        qf       <= s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_nxt;
        cand     <= s2;
      end

      sv_r  <= 1'b0;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;

      // The first accepted qf change after reset only establishes the phase.
      if (chg)
        init_arm <= 1'b0;

      if (bus.clr) begin
        count_r <= '0;
        err_r   <= 1'b0;
      end else if (chg && !init_arm) begin
        if (illegal) begin
          err_r <= 1'b1;
        end else if (step && bus.en) begin
          dir_r <= fwd;
          sv_r  <= 1'b1;
          if (fwd) begin
            ovf_r <= at_max;
            if (!at_max || (WRAP != 0))
              count_r <= count_r + CNT_W'(1);
          end else begin
            unf_r <= at_min;
            if (!at_min || (WRAP != 0))
              count_r <= count_r - CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.count      = count_r;
  assign bus.dir        = dir_r;
  assign bus.step_valid = sv_r;
  assign bus.ovf        = ovf_r;
  assign bus.unf        = unf_r;
  assign bus.err        = err_r;
endmodule

// File: tb/tb_quad_enc_counter.sv
// Bench for quad_enc_counter: three variants (wrap x4, saturate x4, wrap x1) share one
// stimulus stream and are compared every cycle against a sample-window reference model.
module tb_quad_enc_counter;
  localparam int W   = 4;
  localparam int FD  = 2;
  localparam int MAXV = (1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic       Clkb = 1'b0;
  logic       RST  = 1'b0;
  logic [1:0] enc  = 2'b00;
  logic       en   = 1'b1;
  logic       clr  = 1'b0;

  always #5 Clkb = ~Clkb;

  quad_enc_counter_if #(.CNT_W(W)) bus0 ();
  quad_enc_counter_if #(.CNT_W(W)) bus1 ();
  quad_enc_counter_if #(.CNT_W(W)) bus2 ();

  assign bus0.enc_inp = enc;
  assign bus0.en      = en;
  assign bus0.clr     = clr;
  assign bus1.enc_inp = enc;
  assign bus1.en      = en;
  assign bus1.clr     = clr;
  assign bus2.enc_inp = enc;
  assign bus2.en      = en;
  assign bus2.clr     = clr;

  quad_enc_counter #(.CNT_W(W), .FILT_DEPTH(FD), .WRAP(1), .MODE(0)) dut0 (.Clkb(Clkb), .RST(RST), .bus(bus0));
  quad_enc_counter #(.CNT_W(W), .FILT_DEPTH(FD), .WRAP(0), .MODE(0)) dut1 (.Clkb(Clkb), .RST(RST), .bus(bus1));
  quad_enc_counter #(.CNT_W(W), .FILT_DEPTH(FD), .WRAP(1), .MODE(1)) dut2 (.Clkb(Clkb), .RST(RST), .bus(bus2));

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   wrap_p[3] = '{1, 0, 1};
  int   mode_p[3] = '{0, 0, 1};
  logic [1:0] exp_q[$];          // raw encoder sample seen at each falling edge
  logic [1:0] m_qf, p_from, p_to;
  bit   pend, m_init;
  int   m_count[3];
  bit   m_dir[3], m_sv[3], m_ovf[3], m_unf[3], m_err[3];
  bit   seen_sv[3], seen_ovf[3], seen_unf[3];

  function automatic int gray_pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] pos_gray(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic apply_change(input int d);
    int  pf, pt;
    bit  is_fwd, do_step;
    pf = gray_pos(p_from);
    pt = gray_pos(p_to);
    if ((pf + 2) % 4 == pt) begin
      m_err[d] = 1'b1;
      return;
    end
    is_fwd  = ((pf + 1) % 4 == pt);
    do_step = (mode_p[d] == 0) || (is_fwd && pt == 0) || (!is_fwd && pf == 0);
    if (!(do_step && en)) return;
    m_dir[d] = is_fwd;
    m_sv[d]  = 1'b1;
    if (is_fwd) begin
      if (m_count[d] == MAXV) begin
        m_ovf[d] = 1'b1;
        if (wrap_p[d] != 0) m_count[d] = 0;
      end else m_count[d] = m_count[d] + 1;
    end else begin
      if (m_count[d] == 0) begin
        m_unf[d] = 1'b1;
        if (wrap_p[d] != 0) m_count[d] = MAXV;
      end else m_count[d] = m_count[d] - 1;
    end
  endtask

  // One falling edge: outputs react to the qf change accepted on the previous edge, then
  // qf accepts a value once the last FD synchronised samples agree and differ from it.
  task automatic model_edge();
    logic [1:0] v;
    bit same;
    if (RST) begin
      exp_q.delete();
      for (int i = 0; i < FD + 2; i++) exp_q.push_back(2'b00);
      m_qf = 2'b00; pend = 1'b0; m_init = 1'b1;
      for (int d = 0; d < 3; d++) begin
        m_count[d] = 0; m_dir[d] = 0; m_sv[d] = 0; m_ovf[d] = 0; m_unf[d] = 0; m_err[d] = 0;
      end
      return;
    end
    for (int d = 0; d < 3; d++) begin
      m_sv[d] = 0; m_ovf[d] = 0; m_unf[d] = 0;
    end
    if (clr) begin
      for (int d = 0; d < 3; d++) begin
        m_count[d] = 0; m_err[d] = 0;
      end
    end else if (pend && !m_init) begin
      for (int d = 0; d < 3; d++) apply_change(d);
    end
    if (pend) m_init = 1'b0;
    exp_q.push_back(enc);
    pend = 1'b0;
    v    = exp_q[exp_q.size() - 3];
    same = 1'b1;
    for (int j = 3; j <= FD + 2; j++)
      if (exp_q[exp_q.size() - j] != v) same = 1'b0;
    if (same && v != m_qf) begin
      pend = 1'b1; p_from = m_qf; p_to = v; m_qf = v;
    end
    if (exp_q.size() > 32) void'(exp_q.pop_front());
  endtask

  task automatic cmp_dut(input int d, input logic [W-1:0] c, input logic dr, input logic sv,
                         input logic ov, input logic un, input logic er);
    check_val($sformatf("d%0d_count", d), {28'd0, c}, m_count[d]);
    check_val($sformatf("d%0d_dir", d),  {31'd0, dr}, {31'd0, m_dir[d]});
    check_val($sformatf("d%0d_step_valid", d), {31'd0, sv}, {31'd0, m_sv[d]});
    check_val($sformatf("d%0d_ovf", d),  {31'd0, ov}, {31'd0, m_ovf[d]});
    check_val($sformatf("d%0d_unf", d),  {31'd0, un}, {31'd0, m_unf[d]});
    check_val($sformatf("d%0d_err", d),  {31'd0, er}, {31'd0, m_err[d]});
    seen_sv[d]  |= (sv === 1'b1);
    seen_ovf[d] |= (ov === 1'b1);
    seen_unf[d] |= (un === 1'b1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge Clkb);
    model_edge();
    @(posedge Clkb);
    cmp_dut(0, bus0.count, bus0.dir, bus0.step_valid, bus0.ovf, bus0.unf, bus0.err);
    cmp_dut(1, bus1.count, bus1.dir, bus1.step_valid, bus1.ovf, bus1.unf, bus1.err);
    cmp_dut(2, bus2.count, bus2.dir, bus2.step_valid, bus2.ovf, bus2.unf, bus2.err);
  endtask

  task automatic clear_seen();
    for (int d = 0; d < 3; d++) begin
      seen_sv[d] = 0; seen_ovf[d] = 0; seen_unf[d] = 0;
    end
  endtask

  logic [1:0] cur;

  task automatic hold(input logic [1:0] v, input int n);
    enc = v;
    cur = v;
    repeat (n) tick();
  endtask

  task automatic step_fwd(input int n);
    hold(pos_gray(gray_pos(cur) + 1), n);
  endtask

  task automatic step_rev(input int n);
    hold(pos_gray(gray_pos(cur) + 3), n);
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) tick();
    RST = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int lat;
  int r;

  initial begin
    #2 RST = 1'b1;
    repeat (3) tick();
    check_val("rst_count", {28'd0, bus0.count}, 0);
    check_val("rst_err", {31'd0, bus0.err}, 0);
    RST = 1'b0;

    // init phase 11, then forward 11->10->00->01
    hold(2'b11, 8);
    check_val("init_no_count", {28'd0, bus0.count}, 0);
    enc = 2'b10; cur = 2'b10; lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lat < 0 && bus0.step_valid === 1'b1) lat = i;
    end
    check_val("step_latency", lat, 5);
    step_fwd(6);
    step_fwd(6);
    check_val("fwd3_count", {28'd0, bus0.count}, 3);
    check_val("fwd3_dir", {31'd0, bus0.dir}, 1);
    check_val("fwd3_err", {31'd0, bus0.err}, 0);
    check_val("mode1_count", {28'd0, bus2.count}, 1);

    // reverse through zero: wrap to 15 / saturate at 0
    repeat (3) step_rev(6);
    clear_seen();
    step_rev(6);
    check_val("wrap_unf_count", {28'd0, bus0.count}, 15);
    check_val("wrap_unf_pulse", {31'd0, seen_unf[0]}, 1);
    check_val("sat_unf_count", {28'd0, bus1.count}, 0);
    check_val("sat_unf_pulse", {31'd0, seen_unf[1]}, 1);
    check_val("sat_unf_sv", {31'd0, seen_sv[1]}, 1);
    clear_seen();
    step_fwd(6);
    check_val("wrap_ovf_count", {28'd0, bus0.count}, 0);
    check_val("wrap_ovf_pulse", {31'd0, seen_ovf[0]}, 1);
    clear_seen();
    step_rev(6);
    check_val("wrap_unf2_count", {28'd0, bus0.count}, 15);
    check_val("wrap_unf2_pulse", {31'd0, seen_unf[0]}, 1);
    repeat (19) step_fwd(6);
    clear_seen();
    step_fwd(6);
    check_val("sat_ovf_count", {28'd0, bus1.count}, 15);
    check_val("sat_ovf_pulse", {31'd0, seen_ovf[1]}, 1);
    check_val("sat_ovf_sv", {31'd0, seen_sv[1]}, 1);

    // glitch, illegal jump, clear
    step_rev(6);
    clear_seen();
    hold(2'b01, 1);
    hold(2'b00, 8);
    check_val("glitch_no_step", {31'd0, seen_sv[0]}, 0);
    hold(2'b11, 8);
    check_val("illegal_err", {31'd0, bus0.err}, 1);
    check_val("illegal_count", {28'd0, bus0.count}, 2);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    check_val("clr_err", {31'd0, bus0.err}, 0);
    check_val("clr_count", {28'd0, bus0.count}, 0);

    // enable gating
    en = 1'b0;
    repeat (4) step_fwd(6);
    en = 1'b1;
    step_fwd(6);
    check_val("en_gate_count", {28'd0, bus0.count}, 1);

    // clear coincident with a step
    clear_seen();
    enc = pos_gray(gray_pos(cur) + 1); cur = enc;
    for (int i = 1; i <= 10; i++) begin
      clr = (i >= 4 && i <= 6);
      tick();
    end
    clr = 1'b0;
    check_val("clr_step_count", {28'd0, bus0.count}, 0);
    check_val("clr_step_no_sv", {31'd0, seen_sv[0]}, 0);

    // reset in the middle of filtering
    enc = pos_gray(gray_pos(cur) + 1); cur = enc;
    repeat (2) tick();
    clear_seen();
    do_reset(2);
    repeat (8) tick();
    check_val("midrst_count", {28'd0, bus0.count}, 0);
    check_val("midrst_no_sv", {31'd0, seen_sv[0]}, 0);
    check_val("midrst_dir", {31'd0, bus0.dir}, 0);

    // randomized walk
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 99);
      en = ($urandom_range(0, 9) != 0);
      if (r < 40)       step_fwd($urandom_range(1, 7));
      else if (r < 75)  step_rev($urandom_range(1, 7));
      else if (r < 85) begin
        enc = pos_gray(gray_pos(cur) + (($urandom_range(0, 1) != 0) ? 1 : 3));
        repeat ($urandom_range(1, 2)) tick();
        hold(cur, $urandom_range(2, 6));
      end
      else if (r < 90)  hold(cur ^ 2'b11, $urandom_range(3, 7));
      else if (r < 96) begin
        clr = 1'b1; tick(); clr = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
      end
      else do_reset($urandom_range(1, 3));
    end
    en = 1'b1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
